branch_issue_arb: RTL
=====================

BRANCH_ISSUE_ARB -- requirements
Module: branch_issue_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of branch requesters (2..8).
REQ-002 SHALL have parameter TAG_W, default 6, ROB tag width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  NUM_REQ  per-requester branch ready to execute.
REQ-006 SHALL have port req_ready_o  output  NUM_REQ  one-hot grant; a requester's transfer occurs when its valid and ready are both 1.
REQ-007 SHALL have ports req_pc_i [NUM_REQ][64], req_rs1_i [NUM_REQ][64], req_rs2_i [NUM_REQ][64], req_ctrl_i [NUM_REQ][3], req_imm_i [NUM_REQ][32], req_pred_taken_i [NUM_REQ][1], req_pred_target_i [NUM_REQ][64] and req_tag_i [NUM_REQ][TAG_W], all inputs, carrying per-requester branch operands.
REQ-008 SHALL have port rob_head_i  input  TAG_W  oldest in-flight ROB tag, used for age ordering.
REQ-009 SHALL have ports res_valid_o  output  1, res_tag_o  output  TAG_W, res_taken_o  output  1, res_target_o  output  64 and res_mispredict_o  output  1, forming the registered resolution.
REQ-010 SHALL have port res_ready_i  input  1  consumer accepts the resolution.
REQ-011 SHALL have ports redirect_valid_o  output  1 and redirect_pc_o  output  64, giving the front-end redirect.
REQ-012 SHALL have ports flush_i  input  1 (pipeline flush) and flush_done_i  input  1 (front-end redirect complete).
REQ-013 SHALL have ports perf_resolved_o  output  32 and perf_mispred_o  output  32, holding performance counts.

Function
REQ-014 SHALL compute the taken decision and target in a single cycle, using ctrl encoding BEQ0 BNE1 BLT2 BGE3 BLTU4 BGEU5 JAL6 JALR7.
REQ-015 SHALL form the target as pc+sext(imm), except JALR, whose target is (rs1+sext(imm)) with bit0 cleared.
REQ-016 SHALL use pc+4 as the target of a not-taken branch.
REQ-017 SHALL flag a mispredict when pred_taken != taken, or when both are taken and pred_target != target.
REQ-018 SHALL grant the valid requester with the smallest age, where age = (tag - rob_head_i) mod 2^TAG_W; on equal age, the lowest index wins.
REQ-019 SHALL grant at most one requester per cycle, and SHALL grant none in FLUSH_WAIT, in a cycle with flush_i=1, or while res_valid_o=1 and res_ready_i=0.
REQ-020 SHALL keep req_ready_o combinational from the current inputs and state.
REQ-021 SHALL load the granted branch's resolution into the output register at the next edge, giving a latency of 1 cycle from grant to res_valid_o.
REQ-022 SHALL hold all res_* and redirect_* outputs stable while res_valid_o=1 and res_ready_i=0.
REQ-023 SHALL clear res_valid_o on acceptance when no new grant occurs in that cycle.
REQ-024 SHALL support back-to-back issue (throughput of one branch per cycle) when res_ready_i=1.
REQ-025 SHALL implement an FSM with states RUN and FLUSH_WAIT.
REQ-026 SHALL move RUN->FLUSH_WAIT at the edge where a mispredicting branch is granted.
REQ-027 SHALL move FLUSH_WAIT->RUN on flush_done_i=1.
REQ-028 SHALL assert redirect_valid_o exactly when res_valid_o=1 and res_mispredict_o=1, with redirect_pc_o = res_target_o.
REQ-029 SHALL, on flush_i=1, clear res_valid_o and redirect_valid_o at the next edge, force the FSM to RUN, and make no grant.
REQ-030 SHALL give flush_i priority when flush_i and flush_done_i are both 1, and also when flush_i coincides with a pending result (the result is dropped).
REQ-031 SHALL wrap tag-age arithmetic modulo 2^TAG_W, so tag 0x01 is younger than tag 0x3F when head=0x3E.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously force res_valid_o=0, redirect_valid_o=0, FSM=RUN, res_tag_o=0, res_taken_o=0, res_target_o=0, res_mispredict_o=0, redirect_pc_o=0, perf counters=0 and req_ready_o=0.
REQ-033 SHALL discard any in-flight result when reset asserts mid-operation, and SHALL grant no earlier than the first edge after rst_n rises.

Configuration
REQ-034 SHALL, with macro BRANCH_ISSUE_ARB_PERF_EN defined, increment perf_resolved_o on every accepted result and perf_mispred_o on every accepted mispredicted result, each 32-bit and saturating at 0xFFFFFFFF.
REQ-035 SHALL, with BRANCH_ISSUE_ARB_PERF_EN undefined, tie both perf outputs to 0 and contain no counter flops.

Verification
REQ-036 SHALL cover: req0 BEQ rs1=rs2=5, pc=0x1000, imm=0x20, pred_taken=1, pred_target=0x1020 -> one cycle later res_valid=1, taken=1, target=0x1020, mispredict=0, state RUN.
REQ-037 SHALL cover: req1 (tag 0x01) and req2 (tag 0x3F) both valid with head=0x3E -> req2 granted first and req1 on the next cycle.
REQ-038 SHALL cover: JALR rs1=0x2003, imm=0, pred_target=0x2000 -> target=0x2002, mispredict=1, redirect_valid=1, redirect_pc=0x2002, no grants until flush_done_i pulses.
REQ-039 SHALL cover: res_ready_i=0 for 3 cycles with 2 requests pending -> outputs stable for 3 cycles, req_ready_o=0, then both results resolve on consecutive cycles.
REQ-040 SHALL cover: flush_i asserted in the same cycle as a valid result and a new request -> res_valid=0 next cycle and no grant that cycle.
REQ-041 SHALL cover: with BRANCH_ISSUE_ARB_PERF_EN defined, 10 resolves including 3 mispredicts -> perf_resolved=10, perf_mispred=3; with the macro undefined, both read 0.

Source files
------------

// File: rtl/branch_issue_arb.sv
// Branch issue arbiter: picks the oldest ready branch by ROB age, resolves it in one cycle and
// registers the result. Optional counters are compiled in with BRANCH_ISSUE_ARB_PERF_EN.
module branch_issue_arb #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ-1:0][63:0]        req_pc_i,
    input  logic [NUM_REQ-1:0][63:0]        req_rs1_i,
    input  logic [NUM_REQ-1:0][63:0]        req_rs2_i,
    input  logic [NUM_REQ-1:0][2:0]         req_ctrl_i,
    input  logic [NUM_REQ-1:0][31:0]        req_imm_i,
    input  logic [NUM_REQ-1:0]              req_pred_taken_i,
    input  logic [NUM_REQ-1:0][63:0]        req_pred_target_i,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag_i,
    input  logic [TAG_W-1:0]                rob_head_i,
    output logic                            res_valid_o,
    output logic [TAG_W-1:0]                res_tag_o,
    output logic                            res_taken_o,
    output logic [63:0]                     res_target_o,
    output logic                            res_mispredict_o,
    input  logic                            res_ready_i,
    output logic                            redirect_valid_o,
    output logic [63:0]                     redirect_pc_o,
    input  logic                            flush_i,
    input  logic                            flush_done_i,
    output logic [31:0]                     perf_resolved_o,
    output logic [31:0]                     perf_mispred_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] CTRL_BEQ  = 3'd0;
    localparam logic [2:0] CTRL_BNE  = 3'd1;
    localparam logic [2:0] CTRL_BLT  = 3'd2;
    localparam logic [2:0] CTRL_BGE  = 3'd3;
    localparam logic [2:0] CTRL_BLTU = 3'd4;
    localparam logic [2:0] CTRL_BGEU = 3'd5;
    localparam logic [2:0] CTRL_JAL  = 3'd6;
    localparam logic [2:0] CTRL_JALR = 3'd7;

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        FLUSH_WAIT = 1'b1
    } state_t;

    // Distance from the ROB head; modular subtraction handles tag wrap-around.
    function automatic logic [TAG_W-1:0] tag_age(input logic [TAG_W-1:0] tag,
                                                 input logic [TAG_W-1:0] head);
        return tag - head;
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic               run_en_r;
    logic               res_valid_r;
    logic [TAG_W-1:0]   res_tag_r;
    logic               res_taken_r;
    logic [63:0]        res_target_r;
    logic               res_mispredict_r;
    logic               redirect_valid_r;
    logic [63:0]        redirect_pc_r;

    logic               sel_valid_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic [TAG_W-1:0]   best_age_s;
    logic               can_issue_s;
    logic               grant_s;

    logic [63:0]        op_pc_s;
    logic [63:0]        op_rs1_s;
    logic [63:0]        op_rs2_s;
    logic [2:0]         op_ctrl_s;
    logic [31:0]        op_imm_s;
    logic               op_pred_taken_s;
    logic [63:0]        op_pred_target_s;
    logic [TAG_W-1:0]   op_tag_s;

    logic [63:0]        imm_sext_s;
    logic [63:0]        taken_target_s;
    logic               taken_s;
    logic [63:0]        target_s;
    logic               mispredict_s;

    // Oldest-first selection; strict less-than leaves ties with the lowest index.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_idx_s   = '0;
        best_age_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid_i[i] && (!sel_valid_s || (tag_age(req_tag_i[i], rob_head_i) < best_age_s))) begin
                sel_valid_s = 1'b1;
                sel_idx_s   = IDX_W'(i);
                best_age_s  = tag_age(req_tag_i[i], rob_head_i);
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
    end

    // A full, unaccepted result register, a pending flush or a redirect in progress blocks issue.
    assign can_issue_s = run_en_r && (state_r == RUN) && !flush_i && !(res_valid_r && !res_ready_i);
    assign grant_s     = sel_valid_s && can_issue_s;

    // One-hot ready towards the selected requester.
    always_comb begin
        req_ready_o = '0;
        if (grant_s) begin
            req_ready_o[sel_idx_s] = 1'b1;
        end else begin
            req_ready_o = '0;
        end
    end

    assign op_pc_s          = req_pc_i[sel_idx_s];
    assign op_rs1_s         = req_rs1_i[sel_idx_s];
    assign op_rs2_s         = req_rs2_i[sel_idx_s];
    assign op_ctrl_s        = req_ctrl_i[sel_idx_s];
    assign op_imm_s         = req_imm_i[sel_idx_s];
    assign op_pred_taken_s  = req_pred_taken_i[sel_idx_s];
    assign op_pred_target_s = req_pred_target_i[sel_idx_s];
    assign op_tag_s         = req_tag_i[sel_idx_s];

    // Branch condition, target and misprediction of the selected branch.
    always_comb begin
        imm_sext_s = {{32{op_imm_s[31]}}, op_imm_s};
        case (op_ctrl_s)
            CTRL_BEQ:  taken_s = (op_rs1_s == op_rs2_s);
            CTRL_BNE:  taken_s = (op_rs1_s != op_rs2_s);
            CTRL_BLT:  taken_s = ($signed(op_rs1_s) <  $signed(op_rs2_s));
            CTRL_BGE:  taken_s = ($signed(op_rs1_s) >= $signed(op_rs2_s));
            CTRL_BLTU: taken_s = (op_rs1_s <  op_rs2_s);
            CTRL_BGEU: taken_s = (op_rs1_s >= op_rs2_s);
            CTRL_JAL:  taken_s = 1'b1;
            CTRL_JALR: taken_s = 1'b1;
            default:   taken_s = 1'b0;
        endcase
        if (op_ctrl_s == CTRL_JALR) begin
            taken_target_s = (op_rs1_s + imm_sext_s) & ~64'd1;
        end else begin
            taken_target_s = op_pc_s + imm_sext_s;
        end
        if (taken_s) begin
            target_s = taken_target_s;
        end else begin
            target_s = op_pc_s + 64'd4;
        end
        mispredict_s = (op_pred_taken_s != taken_s) ||
                       (taken_s && op_pred_taken_s && (op_pred_target_s != target_s));
    end

    // Issue is held off until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_en_r <= 1'b0;
        end else begin
            run_en_r <= 1'b1;
        end
    end

    // Result register: flush drops it, a grant reloads it, acceptance alone empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r      <= 1'b0;
            res_tag_r        <= '0;
            res_taken_r      <= 1'b0;
            res_target_r     <= 64'd0;
            res_mispredict_r <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 64'd0;
        end else if (flush_i) begin
            res_valid_r      <= 1'b0;
            redirect_valid_r <= 1'b0;
        end else if (grant_s) begin
            res_valid_r      <= 1'b1;
            res_tag_r        <= op_tag_s;
            res_taken_r      <= taken_s;
            res_target_r     <= target_s;
            res_mispredict_r <= mispredict_s;
            redirect_valid_r <= mispredict_s;
            redirect_pc_r    <= target_s;
        end else if (res_ready_i) begin
            res_valid_r      <= 1'b0;
            redirect_valid_r <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; flush overrides everything, including a coincident flush_done.
    always_comb begin
        state_next_s = state_r;
        if (flush_i) begin
            state_next_s = RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (grant_s && mispredict_s) begin
                        state_next_s = FLUSH_WAIT;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                FLUSH_WAIT: begin
                    if (flush_done_i) begin
                        state_next_s = RUN;
                    end else begin
                        state_next_s = FLUSH_WAIT;
                    end
                end
                default: state_next_s = RUN;
            endcase
        end
    end

    assign res_valid_o      = res_valid_r;
    assign res_tag_o        = res_tag_r;
    assign res_taken_o      = res_taken_r;
    assign res_target_o     = res_target_r;
    assign res_mispredict_o = res_mispredict_r;
    assign redirect_valid_o = redirect_valid_r;
    assign redirect_pc_o    = redirect_pc_r;

`ifdef BRANCH_ISSUE_ARB_PERF_EN
    logic        accept_s;
    logic [31:0] perf_resolved_r;
    logic [31:0] perf_mispred_r;

    // A result dropped by a flush is not counted as accepted.
    assign accept_s = res_valid_r && res_ready_i && !flush_i;

    // Saturating resolve and mispredict counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_resolved_r <= 32'd0;
            perf_mispred_r  <= 32'd0;
        end else if (accept_s) begin
            if (perf_resolved_r != 32'hFFFF_FFFF) begin
                perf_resolved_r <= perf_resolved_r + 32'd1;
            end
            if (res_mispredict_r && (perf_mispred_r != 32'hFFFF_FFFF)) begin
                perf_mispred_r <= perf_mispred_r + 32'd1;
            end
        end
    end

    assign perf_resolved_o = perf_resolved_r;
    assign perf_mispred_o  = perf_mispred_r;
`else
    assign perf_resolved_o = 32'd0;
    assign perf_mispred_o  = 32'd0;
`endif

endmodule
